clip_stage: RTL and testbench



---
 rtl/clip_stage.sv | 176 +++++++++++++++++
 tb/tb_clip_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clip_stage.sv
// clip_stage: three-stage clipping pipeline for the overdrive path.
// Stage 1 splits the gained sample into sign and magnitude, stage 2 shapes the
// magnitude (saturate / hard clip / soft knee), stage 3 saturates to 15 bits,
// restores the sign and registers the output. Clip count and peak are metering.
module clip_stage #(
    parameter int knee_shift    = 2,
    parameter int counter_width = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [31:0]              i_sample,
    input  logic [14:0]              i_threshold,
    input  logic [1:0]               i_mode,
    input  logic                     i_clear_stats,
    output logic                     o_valid,
    output logic [15:0]              o_sample,
    output logic                     o_clipped,
    output logic [counter_width-1:0] o_clip_count,
    output logic [14:0]              o_peak
);

    typedef enum logic [1:0] {
        MODE_SAT  = 2'd0,
        MODE_HARD = 2'd1,
        MODE_SOFT = 2'd2,
        MODE_ALT  = 2'd3
    } clip_mode_t;

    localparam logic [31:0] MAX_MAG = 32'd32767;

    // Stage 1 state: sign, magnitude and the controls captured with the sample
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic [14:0] s1_thr;
    clip_mode_t  s1_mode;

    // Stage 2 state: shaped magnitude and threshold-clip flag
    logic        s2_valid;
    logic        s2_sign;
    logic [31:0] s2_mag;
    logic        s2_clip;

    // Magnitude of the registered output, kept for peak tracking
    logic [14:0] out_mag;

    // Combinational results feeding the stage registers
    logic [31:0] in_mag;
    logic [31:0] thr_wide;
    logic [31:0] excess;
    logic        over_thr;
    logic [31:0] shaped_mag;
    logic        shaped_clip;
    logic [14:0] sat_mag;
    logic        sat_clip;
    logic [15:0] signed_out;

    // Absolute value of the input; -2^31 maps to 2^31 as an unsigned 32-bit value
    always_comb begin
        in_mag = i_sample;
        if (i_sample[31]) begin
            in_mag = 32'd0 - i_sample;
        end
    end

    // Stage 1 register: split sign/magnitude and capture threshold and mode
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_thr   <= '0;
            s1_mode  <= MODE_SAT;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                s1_sign <= i_sample[31];
                s1_mag  <= in_mag;
                s1_thr  <= i_threshold;
                s1_mode <= clip_mode_t'(i_mode);
            end
        end
    end

    // Magnitude shaping according to the captured mode
    always_comb begin
        thr_wide    = {17'd0, s1_thr};
        excess      = s1_mag - thr_wide;
        over_thr    = (s1_mag > thr_wide);
        shaped_mag  = s1_mag;
        shaped_clip = 1'b0;
        case (s1_mode)
            MODE_HARD: begin
                if (over_thr) begin
                    shaped_mag  = thr_wide;
                    shaped_clip = 1'b1;
                end
            end
            MODE_SOFT: begin
                if (over_thr) begin
                    shaped_mag  = thr_wide + (excess >> knee_shift);
                    shaped_clip = 1'b1;
                end
            end
            default: begin
                shaped_mag  = s1_mag;
                shaped_clip = 1'b0;
            end
        endcase
    end

    // Stage 2 register: shaped magnitude and its clip flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_clip  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= shaped_mag;
                s2_clip <= shaped_clip;
            end
        end
    end

    // Final saturation to a symmetric 16-bit range and sign restoration
    always_comb begin
        sat_mag  = s2_mag[14:0];
        sat_clip = s2_clip;
        if (s2_mag > MAX_MAG) begin
            sat_mag  = 15'h7FFF;
            sat_clip = 1'b1;
        end
        signed_out = {1'b0, sat_mag};
        if (s2_sign) begin
            signed_out = 16'd0 - {1'b0, sat_mag};
        end
    end

    // Output register: data holds its last value while no sample is valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_sample  <= '0;
            o_clipped <= 1'b0;
            out_mag   <= '0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_sample  <= signed_out;
                o_clipped <= sat_clip;
                out_mag   <= sat_mag;
            end
        end
    end

    // Metering: saturating clip counter and peak hold, clear wins over update
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear_stats) begin
            o_clip_count <= '0;
            o_peak       <= '0;
        end else if (o_valid) begin
            if (o_clipped && (o_clip_count != {counter_width{1'b1}})) begin
                o_clip_count <= o_clip_count + counter_width'(1);
            end
            if (out_mag > o_peak) begin
                o_peak <= out_mag;
            end
        end
    end

endmodule

// File: tb/tb_clip_stage.sv
// tb_clip_stage: directed-vector bench for clip_stage with hand-computed
// expected outputs, latency checks and metering checks.
module tb_clip_stage;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inSample;
    logic [14:0] inThreshold;
    logic [1:0]  inMode;
    logic        clearStats;
    logic        outValid;
    logic [15:0] outSample;
    logic        outClipped;
    logic [3:0]  clipCount;
    logic [14:0] peak;

    int totalChecks = 0;
    int badChecks   = 0;
    int cyc         = 0;

    int outVals[$];
    int outClips[$];
    int outCycs[$];
    int drvCycs[$];

    clip_stage #(
        .knee_shift    (2),
        .counter_width (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (inValid),
        .i_sample      (inSample),
        .i_threshold   (inThreshold),
        .i_mode        (inMode),
        .i_clear_stats (clearStats),
        .o_valid       (outValid),
        .o_sample      (outSample),
        .o_clipped     (outClipped),
        .o_clip_count  (clipCount),
        .o_peak        (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure latency
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (outValid) begin
            outVals.push_back(int'($signed(outSample)));
            outClips.push_back(int'(outClipped));
            outCycs.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] s, input logic [14:0] t, input logic [1:0] m);
        @(negedge clk);
        inValid     = 1'b1;
        inSample    = s;
        inThreshold = t;
        inMode      = m;
        drvCycs.push_back(cyc);
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            inValid    = 1'b0;
            clearStats = 1'b0;
        end
    endtask

    task automatic clearQueues();
        outVals.delete();
        outClips.delete();
        outCycs.delete();
        drvCycs.delete();
    endtask

    task automatic pulseClear();
        @(negedge clk);
        inValid    = 1'b0;
        clearStats = 1'b1;
        @(negedge clk);
        clearStats = 1'b0;
    endtask

    // Bounded wait for n outputs, then confirm no extra outputs appear
    task automatic waitOutputs(input string tag, input int n);
        for (int k = 0; k < 40 && outVals.size() < n; k++) begin
            @(negedge clk);
            inValid = 1'b0;
        end
        idleCycles(4);
        checkOutput({tag, "_count"}, outVals.size(), n);
    endtask

    task automatic checkItem(input string tag, input int idx, input int expVal, input int expClip);
        int v, c, lat;
        v = 99999; c = 9; lat = -1;
        if (idx < outVals.size()) begin
            v = outVals[idx];
            c = outClips[idx];
        end
        if (idx < outCycs.size() && idx < drvCycs.size()) begin
            lat = outCycs[idx] - drvCycs[idx];
        end
        checkOutput($sformatf("%s_val%0d", tag, idx), v, expVal);
        checkOutput($sformatf("%s_clip%0d", tag, idx), c, expClip);
        checkOutput($sformatf("%s_lat%0d", tag, idx), lat, 3);
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inSample = '0; inThreshold = '0;
        inMode = '0; clearStats = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", int'(outValid), 0);
        checkOutput("rst_sample", int'(outSample), 0);
        checkOutput("rst_clipped", int'(outClipped), 0);
        checkOutput("rst_count", int'(clipCount), 0);
        checkOutput("rst_peak", int'(peak), 0);
        rst = 1'b0;
        idleCycles(2);

        $display("[TB] latency/throughput, mode 0");
        clearQueues();
        applyStimulus(32'd100, 15'd0, 2'd0);
        applyStimulus(-32'sd100, 15'd0, 2'd0);
        applyStimulus(32'd0, 15'd0, 2'd0);
        applyStimulus(32'd32767, 15'd0, 2'd0);
        waitOutputs("m0", 4);
        checkItem("m0", 0, 100, 0);
        checkItem("m0", 1, -100, 0);
        checkItem("m0", 2, 0, 0);
        checkItem("m0", 3, 32767, 0);
        checkOutput("m0_peak", int'(peak), 32767);
        checkOutput("m0_count", int'(clipCount), 0);
        checkOutput("m0_hold", int'($signed(outSample)), 32767);

        $display("[TB] saturation, mode 0");
        pulseClear();
        clearQueues();
        applyStimulus(32'h7FFF_FFFF, 15'd0, 2'd0);
        applyStimulus(32'h8000_0000, 15'd0, 2'd0);
        applyStimulus(32'd40000, 15'd0, 2'd0);
        waitOutputs("sat", 3);
        checkItem("sat", 0, 32767, 1);
        checkItem("sat", 1, -32767, 1);
        checkItem("sat", 2, 32767, 1);
        checkOutput("sat_count", int'(clipCount), 3);
        checkOutput("sat_peak", int'(peak), 32767);

        $display("[TB] hard clip, T=8192");
        pulseClear();
        clearQueues();
        applyStimulus(32'd20000, 15'd8192, 2'd1);
        applyStimulus(-32'sd20000, 15'd8192, 2'd1);
        applyStimulus(32'd8192, 15'd8192, 2'd1);
        applyStimulus(32'd8193, 15'd8192, 2'd1);
        waitOutputs("hard", 4);
        checkItem("hard", 0, 8192, 1);
        checkItem("hard", 1, -8192, 1);
        checkItem("hard", 2, 8192, 0);
        checkItem("hard", 3, 8192, 1);
        checkOutput("hard_count", int'(clipCount), 3);
        checkOutput("hard_peak", int'(peak), 8192);

        $display("[TB] soft knee, T=8192");
        clearQueues();
        applyStimulus(32'd16384, 15'd8192, 2'd2);
        applyStimulus(-32'sd16384, 15'd8192, 2'd2);
        applyStimulus(32'h0010_0000, 15'd8192, 2'd2);
        waitOutputs("soft", 3);
        checkItem("soft", 0, 10240, 1);
        checkItem("soft", 1, -10240, 1);
        checkItem("soft", 2, 32767, 1);

        $display("[TB] threshold zero, mode 3, boundary threshold");
        clearQueues();
        applyStimulus(32'd5, 15'd0, 2'd1);
        applyStimulus(32'd400, 15'd0, 2'd2);
        applyStimulus(32'd500, 15'd10, 2'd3);
        applyStimulus(32'd0, 15'd0, 2'd2);
        applyStimulus(-32'sd40000, 15'd32767, 2'd1);
        waitOutputs("edge", 5);
        checkItem("edge", 0, 0, 1);
        checkItem("edge", 1, 100, 1);
        checkItem("edge", 2, 500, 0);
        checkItem("edge", 3, 0, 0);
        checkItem("edge", 4, -32767, 1);

        $display("[TB] counter saturation and clear priority");
        pulseClear();
        clearQueues();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(32'd1000, 15'd100, 2'd1);
        end
        waitOutputs("cnt", 20);
        checkOutput("cnt_hold15", int'(clipCount), 15);
        checkOutput("cnt_peak", int'(peak), 100);
        clearQueues();
        applyStimulus(32'd40000, 15'd0, 2'd0);
        idleCycles(2);
        @(negedge clk);
        clearStats = 1'b1;
        checkOutput("clr_valid_now", int'(outValid), 1);
        @(negedge clk);
        clearStats = 1'b0;
        checkOutput("clr_count", int'(clipCount), 0);
        checkOutput("clr_peak", int'(peak), 0);
        idleCycles(2);
        checkOutput("clr_count_after", int'(clipCount), 0);

        $display("[TB] reset mid-stream");
        applyStimulus(32'd30000, 15'd0, 2'd0);
        idleCycles(4);
        checkOutput("pre_rst_count", int'(clipCount), 0);
        checkOutput("pre_rst_peak", int'(peak), 30000);
        clearQueues();
        applyStimulus(32'd1234, 15'd0, 2'd0);
        applyStimulus(32'd50000, 15'd0, 2'd0);
        @(negedge clk);
        inValid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idleCycles(5);
        checkOutput("rst_mid_outputs", outVals.size(), 0);
        checkOutput("rst_mid_sample", int'(outSample), 0);
        checkOutput("rst_mid_clipped", int'(outClipped), 0);
        checkOutput("rst_mid_count", int'(clipCount), 0);
        checkOutput("rst_mid_peak", int'(peak), 0);
        clearQueues();
        applyStimulus(-32'sd777, 15'd0, 2'd0);
        waitOutputs("post_rst", 1);
        checkItem("post_rst", 0, -777, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
